// File: rtl/register_unit_if.sv
// Operand interface of the integer register file: write-back request in,
// two combinational read ports and pending-stage status out.
interface register_unit_if #(
  parameter int XLEN = 32
);
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic            RUWr;
  logic [XLEN-1:0] DataWr;
  logic [XLEN-1:0] RURs1;
  logic [XLEN-1:0] RURs2;
  logic            WbPending;
  logic [4:0]      WbRd;

  modport master (
    output rs1, rs2, rd, RUWr, DataWr,
    input  RURs1, RURs2, WbPending, WbRd
  );

  modport slave (
    input  rs1, rs2, rd, RUWr, DataWr,
    output RURs1, RURs2, WbPending, WbRd
  );
endinterface

// File: rtl/register_unit.sv
// Integer register file with a one-entry write-back stage in front of the
// array; full forwarding hides that stage from both read ports.
module register_unit #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] SP_RESET = 32'h000003FC
) (
  input  logic           clk,
  input  logic           rst,
  register_unit_if.slave ru
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic            pend_valid_q, pend_valid_d;
  logic [4:0]      pend_rd_q,    pend_rd_d;
  logic [XLEN-1:0] pend_data_q,  pend_data_d;

  // Commit the older entry and capture the newer one on the same edge, so a
  // repeated rd leaves the older value in the array and the newer in pending.
  always_comb begin
    regs_d       = regs_q;
    pend_valid_d = 1'b0;
    pend_rd_d    = 5'd0;
    pend_data_d  = pend_data_q;
    if (pend_valid_q) begin
      regs_d[pend_rd_q] = pend_data_q;
    end
    if (ru.RUWr && (ru.rd != 5'd0)) begin
      pend_valid_d = 1'b1;
      pend_rd_d    = ru.rd;
      pend_data_d  = ru.DataWr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == 2) ? SP_RESET : '0;
      end
      pend_valid_q <= 1'b0;
      pend_rd_q    <= 5'd0;
      pend_data_q  <= '0;
    end else begin
      regs_q       <= regs_d;
      pend_valid_q <= pend_valid_d;
      pend_rd_q    <= pend_rd_d;
      pend_data_q  <= pend_data_d;
    end
  end

  logic [1:0][4:0]      rd_idx;
  logic [1:0][XLEN-1:0] rd_val;

  assign rd_idx[0] = ru.rs1;
  assign rd_idx[1] = ru.rs2;

  // Youngest source wins: same-cycle request, then pending stage, then array.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
      assign rd_val[gi] =
        (rd_idx[gi] == 5'd0)                     ? '0          :
        (ru.RUWr && (ru.rd == rd_idx[gi]))       ? ru.DataWr   :
        (pend_valid_q && (pend_rd_q == rd_idx[gi])) ? pend_data_q :
                                                   regs_q[rd_idx[gi]];
    end
  endgenerate

  assign ru.RURs1     = rd_val[0];
  assign ru.RURs2     = rd_val[1];
  assign ru.WbPending = pend_valid_q;
  assign ru.WbRd      = pend_rd_q;

endmodule

// File: tb/tb_register_unit.sv
// Self-checking bench for register_unit: directed scenarios plus randomized
// traffic against an architectural-state model of the register file.
module tb_register_unit;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] SP_RESET = 32'h000003FC;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // Architectural view: a write is visible from the edge that captures it.
  logic [XLEN-1:0] arch [32];
  logic            exp_pend;
  logic [4:0]      exp_wbrd;

  register_unit_if #(.XLEN(XLEN)) ifc ();

  register_unit #(
    .XLEN    (XLEN),
    .NREGS   (32),
    .SP_RESET(SP_RESET)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ru (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] exp_read(input logic [4:0] idx);
    if (idx == 5'd0) return '0;
    if (ifc.RUWr && ifc.rd == idx) return ifc.DataWr;
    return arch[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) arch[i] = (i == 2) ? SP_RESET : '0;
    exp_pend = 1'b0;
    exp_wbrd = 5'd0;
  endtask

  task automatic tick();
    if (ifc.RUWr && ifc.rd != 5'd0) begin
      arch[ifc.rd] = ifc.DataWr;
      exp_pend     = 1'b1;
      exp_wbrd     = ifc.rd;
    end else begin
      exp_pend = 1'b0;
      exp_wbrd = 5'd0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [4:0] rd, input logic [XLEN-1:0] d,
                       input logic [4:0] r1, input logic [4:0] r2);
    ifc.RUWr   = wr;
    ifc.rd     = rd;
    ifc.DataWr = d;
    ifc.rs1    = r1;
    ifc.rs2    = r2;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 5'd5, 32'h55, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd2, 5'd5);
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (ifc.RURs1 !== SP_RESET) begin
      failures++;
      $display("FAIL reset_rs1_sp got=%h want=%h", ifc.RURs1, SP_RESET);
    end
    checks++;
    if (ifc.RURs2 !== 32'h0) begin
      failures++;
      $display("FAIL reset_rs2_zero got=%h want=%h", ifc.RURs2, 32'h0);
    end
    checks++;
    if (ifc.WbPending !== 1'b0) begin
      failures++;
      $display("FAIL reset_wbpending got=%b want=0", ifc.WbPending);
    end
    $display("test_reset: async reset rs1=2 rs2=5 -> %h %h", ifc.RURs1, ifc.RURs2);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_bypass();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd5);
    checks++;
    if (ifc.RURs2 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL bypass_same_cycle got=%h want=%h", ifc.RURs2, 32'hDEADBEEF);
    end
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd5);
    checks++;
    if (ifc.RURs2 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL bypass_pending got=%h want=%h", ifc.RURs2, 32'hDEADBEEF);
    end
    checks++;
    if (ifc.WbPending !== 1'b1 || ifc.WbRd !== 5'd5) begin
      failures++;
      $display("FAIL bypass_pending_stage got=%b/%0d want=1/5", ifc.WbPending, ifc.WbRd);
    end
    tick();
    checks++;
    if (ifc.WbPending !== 1'b0 || ifc.WbRd !== 5'd0) begin
      failures++;
      $display("FAIL bypass_drained got=%b/%0d want=0/0", ifc.WbPending, ifc.WbRd);
    end
    checks++;
    if (ifc.RURs2 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL bypass_array got=%h want=%h", ifc.RURs2, 32'hDEADBEEF);
    end
    $display("test_bypass: x5 write/pending/array -> %h", ifc.RURs2);
  endtask

  task automatic test_x0();
    drive(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
    checks++;
    if (ifc.RURs1 !== 32'h0) begin
      failures++;
      $display("FAIL x0_bypass got=%h want=0", ifc.RURs1);
    end
    for (int e = 0; e < 2; e++) begin
      tick();
      checks++;
      if (ifc.RURs1 !== 32'h0) begin
        failures++;
        $display("FAIL x0_read edge=%0d got=%h want=0", e, ifc.RURs1);
      end
      checks++;
      if (ifc.WbPending !== 1'b0) begin
        failures++;
        $display("FAIL x0_wbpending edge=%0d got=%b want=0", e, ifc.WbPending);
      end
    end
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    $display("test_x0: write to x0 dropped, read=%h", ifc.RURs1);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 5'd7, 32'h1, 5'd7, 5'd7);
    tick();
    checks++;
    if (ifc.RURs1 !== 32'h1) begin
      failures++;
      $display("FAIL b2b_first got=%h want=1", ifc.RURs1);
    end
    drive(1'b1, 5'd7, 32'h2, 5'd7, 5'd7);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    checks++;
    if (ifc.RURs1 !== 32'h2 || ifc.WbRd !== 5'd7) begin
      failures++;
      $display("FAIL b2b_second got=%h/%0d want=2/7", ifc.RURs1, ifc.WbRd);
    end
    tick();
    checks++;
    if (ifc.WbPending !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drained got=%b want=0", ifc.WbPending);
    end
    checks++;
    if (ifc.RURs2 !== 32'h2) begin
      failures++;
      $display("FAIL b2b_array got=%h want=2", ifc.RURs2);
    end
    $display("test_back_to_back: x7 final=%h", ifc.RURs2);
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 5'd9, 32'hAA, 5'd9, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checks++;
    if (ifc.RURs1 !== 32'h0) begin
      failures++;
      $display("FAIL midreset_x9 got=%h want=0", ifc.RURs1);
    end
    checks++;
    if (ifc.WbPending !== 1'b0) begin
      failures++;
      $display("FAIL midreset_wbpending got=%b want=0", ifc.WbPending);
    end
    $display("test_mid_reset: x9 after reset=%h", ifc.RURs1);
  endtask

  task automatic test_dual_port();
    drive(1'b1, 5'd3, 32'h10, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd4, 32'h20, 5'd3, 5'd4);
    checks++;
    if (ifc.RURs1 !== 32'h10) begin
      failures++;
      $display("FAIL dual_rs1 got=%h want=10", ifc.RURs1);
    end
    checks++;
    if (ifc.RURs2 !== 32'h20) begin
      failures++;
      $display("FAIL dual_rs2 got=%h want=20", ifc.RURs2);
    end
    $display("test_dual_port: rs1=%h rs2=%h", ifc.RURs1, ifc.RURs2);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
  endtask

  task automatic test_random();
    logic [XLEN-1:0] e1, e2;
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 8)), 5'($urandom_range(0, 8)));
      e1 = exp_read(ifc.rs1);
      e2 = exp_read(ifc.rs2);
      checks++;
      if (ifc.RURs1 !== e1) begin
        failures++;
        $display("FAIL rand_rs1 n=%0d rs1=%0d got=%h want=%h", n, ifc.rs1, ifc.RURs1, e1);
      end
      checks++;
      if (ifc.RURs2 !== e2) begin
        failures++;
        $display("FAIL rand_rs2 n=%0d rs2=%0d got=%h want=%h", n, ifc.rs2, ifc.RURs2, e2);
      end
      checks++;
      if (ifc.WbPending !== exp_pend || ifc.WbRd !== exp_wbrd) begin
        failures++;
        $display("FAIL rand_stage n=%0d got=%b/%0d want=%b/%0d", n, ifc.WbPending, ifc.WbRd,
                 exp_pend, exp_wbrd);
      end
      $display("rand n=%0d wr=%b rd=%0d d=%h rs1=%0d:%h rs2=%0d:%h", n, ifc.RUWr, ifc.rd,
               ifc.DataWr, ifc.rs1, ifc.RURs1, ifc.rs2, ifc.RURs2);
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    ifc.RUWr   = 1'b0;
    ifc.rd     = 5'd0;
    ifc.DataWr = '0;
    ifc.rs1    = 5'd0;
    ifc.rs2    = 5'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_bypass();
    test_x0();
    test_back_to_back();
    test_mid_reset();
    test_dual_port();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_unit.md
Name: register_unit

Overview:
- Integer register file that produces the Ars2 operand consumed by the ALU operand-B select, plus the rs1 operand.
- Write side of the operand interface: accepts write-back results and returns register contents on two combinational read ports.
- Writes pass through a one-entry write-back pipeline register before committing to the array.
- Full forwarding makes the pipeline stage invisible to readers.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (index width is 5).
- SP_RESET, 32'h000003FC, reset value of register x2 (stack pointer).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- rs1  input  5  read index, port 1.
- rs2  input  5  read index, port 2.
- rd  input  5  write index.
- RUWr  input  1  write request, sampled at the rising edge of clk.
- DataWr  input  XLEN  write data.
- RURs1  output  XLEN  contents of rs1, combinational.
- RURs2  output  XLEN  contents of rs2, combinational (feeds Ars2).
- WbPending  output  1  pending-write stage holds a valid entry.
- WbRd  output  5  index held in the pending stage; 0 when not pending.

Behaviour:
- Reset, asynchronous, while rst=1:
  - All registers become 0, except x2, which becomes SP_RESET.
  - Pending stage cleared: WbPending=0, WbRd=0, pending data=0.
  - RURs1 and RURs2 reflect the cleared array through the normal read path; they are not forced.
  - Reset asserted mid-operation drops any pending write; it never commits.
- Write pipeline, at each rising edge with rst=0:
  - Commit: if WbPending=1, array[WbRd] <= pending data.
  - Capture: if RUWr=1 and rd!=0, then pending <= {valid=1, rd, DataWr}; otherwise pending valid <= 0 and WbRd <= 0.
  - Commit and capture occur on the same edge, so back-to-back writes sustain one write per cycle with no stall.
  - Write latency: data is architecturally visible immediately through forwarding and resides in the array 2 edges after the request.
- x0:
  - Always reads 0.
  - A write with rd=0 is dropped and does not set WbPending.
- Read path, per port, combinational; priority high to low:
  1. index==0 -> 0.
  2. RUWr=1 and rd==index and rd!=0 -> DataWr (same-cycle bypass).
  3. WbPending=1 and WbRd==index -> pending data.
  4. Otherwise -> array[index].
- Both read ports are independent and may read the same index.
- Simultaneous events:
  - Same rd in consecutive cycles: the younger write wins at every read priority level and in the final array contents.
  - A pending commit and a new capture to the same rd on one edge: the array receives the older value and pending holds the newer value, so reads return the newer value.
- RUWr or rd changing between edges affects only the bypass path. Only values present at the rising edge are captured.
- No X-propagation:
  - An out-of-range index cannot occur (5 bits, 32 registers).
  - Every output is defined in every state.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with rs1=2, rs2=5 -> RURs1=32'h000003FC and RURs2=0 immediately, without waiting for clk; WbPending=0.
- Same-cycle bypass: RUWr=1, rd=5, DataWr=32'hDEADBEEF, rs2=5, before the edge -> RURs2=32'hDEADBEEF. After the edge, RUWr=0 -> RURs2 still 32'hDEADBEEF (from pending), WbPending=1, WbRd=5. After a second edge -> WbPending=0 and RURs2=32'hDEADBEEF (from the array).
- x0: RUWr=1, rd=0, DataWr=32'h12345678, then 2 edges -> RURs1 with rs1=0 stays 0; WbPending stays 0.
- Back-to-back same register: write x7=32'h1, then x7=32'h2 on consecutive edges, then idle -> reads after each edge return 1, then 2, then 2; final array x7=32'h2.
- Mid-operation reset: write x9=32'hAA, and on the cycle after its edge (WbPending=1) assert rst -> after release, rs1=9 reads 0 and WbPending=0.
- Dual port: write x3=32'h10 and commit; on the next cycle RUWr=1, rd=4, DataWr=32'h20, rs1=3, rs2=4 -> RURs1=32'h10 and RURs2=32'h20 in the same cycle.
